// File: rtl/decode_issue_queue.sv
// Fetch-to-decode instruction buffer: DEPTH-entry circular queue feeding a registered
// decoder word. It holds that word under hazard and injects NOP bubbles when it has nothing to send.
module decode_issue_queue #(
  parameter int          IW       = 16,
  parameter int          DEPTH    = 4,
  parameter logic [IW-1:0] NOP_WORD = '0,
  parameter int          AF_LEVEL = 3,
  localparam int         PW       = $clog2(DEPTH),
  localparam int         CW       = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          n_RST,
  input  logic          flush,
  input  logic          f_valid,
  input  logic          p_cache_miss,
  input  logic [IW-1:0] f_I,
  output logic          f_ready,
  input  logic          hazard,
  output logic [IW-1:0] d_I,
  output logic          d_valid,
  output logic          d_nop,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          almost_full,
  output logic          overflow_err
);

  logic [IW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          push, wr_en;

  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign almost_full = (count >= CW'(AF_LEVEL));
  assign f_ready     = ~full;
  assign d_nop       = ~d_valid;
  assign push        = f_valid & ~p_cache_miss & f_ready;
  // The queue is only written when the word cannot bypass straight into d_I.
  assign wr_en       = ~flush & push & (hazard | ~empty);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= f_I;
  end

  always_ff @(posedge clk or negedge n_RST) begin
    if (!n_RST) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      d_I     <= NOP_WORD;
      d_valid <= 1'b0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      d_I     <= NOP_WORD;
      d_valid <= 1'b0;
    end else if (hazard) begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= count + 1'b1;
      end
    end else if (!empty) begin
      // Pop and an optional push in the same cycle leave count unchanged.
      d_I     <= mem[rd_ptr];
      d_valid <= 1'b1;
      rd_ptr  <= rd_ptr + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      else      count  <= count - 1'b1;
    end else if (push) begin
      d_I     <= f_I;
      d_valid <= 1'b1;
    end else begin
      d_I     <= NOP_WORD;
      d_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_RST) begin
    if (!n_RST)                                overflow_err <= 1'b0;
    else if (f_valid & ~p_cache_miss & ~f_ready) overflow_err <= 1'b1;
  end

endmodule

// File: tb/tb_decode_issue_queue.sv
// Directed bench for decode_issue_queue: bypass, hazard fill, drain order, overflow,
// flush, cache miss, wraparound with simultaneous push/pop, async reset.
module tb_decode_issue_queue;
  logic        clk = 1'b0;
  logic        n_RST, flush, f_valid, p_cache_miss, hazard;
  logic [15:0] f_I, d_I;
  logic        f_ready, d_valid, d_nop, empty, full, almost_full, overflow_err;
  logic [2:0]  count;
  int          n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  decode_issue_queue dut (
    .clk(clk), .n_RST(n_RST), .flush(flush), .f_valid(f_valid), .p_cache_miss(p_cache_miss),
    .f_I(f_I), .f_ready(f_ready), .hazard(hazard), .d_I(d_I), .d_valid(d_valid), .d_nop(d_nop),
    .count(count), .empty(empty), .full(full), .almost_full(almost_full),
    .overflow_err(overflow_err)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] w, input logic hz);
    f_valid = v;
    f_I     = w;
    hazard  = hz;
  endtask

  initial begin
    n_RST = 1'b0; flush = 1'b0; p_cache_miss = 1'b0;
    drive(1'b0, 16'h0, 1'b0);
    step(); step();
    chk("rst_d_I", d_I, 16'h0000);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_d_nop", d_nop, 1);
    chk("rst_empty", empty, 1);
    chk("rst_f_ready", f_ready, 1);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow_err, 0);
    chk("rst_count", count, 0);
    n_RST = 1'b1;
    step();
    chk("idle_d_valid", d_valid, 0);
    chk("idle_empty", empty, 1);

    // Bypass on empty queue
    drive(1'b1, 16'h2A05, 1'b0);
    step();
    chk("byp_d_I", d_I, 16'h2A05);
    chk("byp_d_valid", d_valid, 1);
    chk("byp_count", count, 0);

    // Fill under hazard
    drive(1'b1, 16'h1101, 1'b1); step();
    chk("f1_count", count, 1);
    chk("f1_hold", d_I, 16'h2A05);
    drive(1'b1, 16'h1102, 1'b1); step();
    chk("f2_count", count, 2);
    chk("f2_af", almost_full, 0);
    drive(1'b1, 16'h1103, 1'b1); step();
    chk("f3_count", count, 3);
    chk("f3_af", almost_full, 1);
    chk("f3_full", full, 0);
    drive(1'b1, 16'h1104, 1'b1); step();
    chk("f4_count", count, 4);
    chk("f4_full", full, 1);
    chk("f4_f_ready", f_ready, 0);
    chk("f4_hold", d_I, 16'h2A05);
    chk("f4_dval", d_valid, 1);

    // Overflow attempt
    drive(1'b1, 16'hFFFF, 1'b1); step();
    chk("ovf_set", overflow_err, 1);
    chk("ovf_count", count, 4);

    // Drain in order
    drive(1'b0, 16'h0, 1'b0); step();
    chk("d1", d_I, 16'h1101); chk("d1_count", count, 3);
    step();
    chk("d2", d_I, 16'h1102); chk("d2_count", count, 2);
    step();
    chk("d3", d_I, 16'h1103);
    step();
    chk("d4", d_I, 16'h1104); chk("d4_count", count, 0);
    step();
    chk("d5_nop", d_I, 16'h0000);
    chk("d5_dval", d_valid, 0);
    chk("d5_dnop", d_nop, 1);
    chk("ovf_sticky", overflow_err, 1);

    // Flush with 3 queued words and a same-cycle push
    drive(1'b1, 16'h00A1, 1'b1); step();
    drive(1'b1, 16'h00A2, 1'b1); step();
    drive(1'b1, 16'h00A3, 1'b1); step();
    chk("fl_pre_count", count, 3);
    flush = 1'b1;
    drive(1'b1, 16'hE000, 1'b1); step();
    chk("fl_count", count, 0);
    chk("fl_dval", d_valid, 0);
    chk("fl_d_I", d_I, 16'h0000);
    flush = 1'b0;
    drive(1'b0, 16'h0, 1'b0); step();
    chk("fl_after_dval", d_valid, 0);
    chk("fl_after_d_I", d_I, 16'h0000);

    // Cache miss suppresses push
    p_cache_miss = 1'b1;
    drive(1'b1, 16'h5555, 1'b0); step();
    chk("cm_dval", d_valid, 0);
    chk("cm_count", count, 0);
    drive(1'b1, 16'h5555, 1'b1); step();
    chk("cm_hz_count", count, 0);
    p_cache_miss = 1'b0;

    // Simultaneous push/pop across pointer wrap
    drive(1'b1, 16'h00B1, 1'b1); step();
    drive(1'b1, 16'h00B2, 1'b1); step();
    drive(1'b1, 16'h00B3, 1'b0); step();
    chk("pp1", d_I, 16'h00B1); chk("pp1_count", count, 2);
    drive(1'b1, 16'h00B4, 1'b0); step();
    chk("pp2", d_I, 16'h00B2); chk("pp2_count", count, 2);
    drive(1'b0, 16'h0, 1'b0); step();
    chk("pp3", d_I, 16'h00B3);
    step();
    chk("pp4", d_I, 16'h00B4); chk("pp4_count", count, 0);
    step();
    chk("pp5_dval", d_valid, 0);

    // Asynchronous reset mid-stall
    drive(1'b1, 16'h00C0, 1'b0); step();
    chk("ar_byp", d_I, 16'h00C0);
    drive(1'b1, 16'h00C1, 1'b1); step();
    drive(1'b1, 16'h00C2, 1'b1); step();
    chk("ar_pre_count", count, 2);
    chk("ar_pre_dval", d_valid, 1);
    #2 n_RST = 1'b0;
    #1;
    chk("ar_count", count, 0);
    chk("ar_dval", d_valid, 0);
    chk("ar_d_I", d_I, 16'h0000);
    chk("ar_ovf", overflow_err, 0);
    chk("ar_f_ready", f_ready, 1);
    drive(1'b0, 16'h0, 1'b0);
    step();
    n_RST = 1'b1;
    step();
    chk("post_empty", empty, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
